// File: rtl/lht_mp_pkg.sv
// Shared defaults, types and index helpers for the multi-update-port local history table.
package lht_mp_pkg;

    localparam int unsigned LHT_SETS_DFLT              = 32;
    localparam int unsigned LHT_ENTRIES_PER_BLOCK_DFLT = 8;
    localparam int unsigned LH_LENGTH_DFLT             = 8;
    localparam int unsigned ASID_WIDTH_DFLT            = 9;
    localparam int unsigned N_UPDATE_DFLT              = 2;
    localparam int unsigned UQ_DEPTH_DFLT              = 4;

    localparam int unsigned LHT_ROW_W = $clog2(LHT_SETS_DFLT);
    localparam int unsigned LHT_ENT_W = $clog2(LHT_ENTRIES_PER_BLOCK_DFLT);

    typedef logic [LHT_ROW_W-1:0]      lht_row_t;
    typedef logic [LHT_ENT_W-1:0]      lht_ent_t;
    typedef logic [LH_LENGTH_DFLT-1:0] lh_t;

    typedef enum logic {
        LHT_INIT = 1'b0,
        LHT_RUN  = 1'b1
    } lht_state_t;

    // One pending history write, already reduced to its table coordinates.
    typedef struct packed {
        lht_row_t row;
        lht_ent_t entry;
        lh_t      lh;
    } uq_entry_t;

    // Row is the block-address bits above the slot offset, hashed with the low ASID bits.
    function automatic lht_row_t lht_row(input logic [31:0] pc,
                                         input logic [ASID_WIDTH_DFLT-1:0] asid);
        return pc[LHT_ENT_W+LHT_ROW_W:LHT_ENT_W+1] ^ asid[LHT_ROW_W-1:0];
    endfunction

    // Entry is the 2-byte instruction slot within the fetch block.
    function automatic lht_ent_t lht_entry(input logic [31:0] pc);
        return pc[LHT_ENT_W:1];
    endfunction

endpackage

// File: rtl/lht_mp_ram.sv
// Table storage: one read port with registered output, one per-entry-enabled write port,
// and write-first forwarding from the write port into the read result.
module lht_mp_ram #(
    parameter int unsigned SETS    = 32,
    parameter int unsigned ENTRIES = 8,
    parameter int unsigned LH_W    = 8
) (
    input  logic                               CLK,
    input  logic                               nRST,
    input  logic                               rd_en,
    input  logic [$clog2(SETS)-1:0]            rd_row,
    output logic [ENTRIES-1:0][LH_W-1:0]       rd_data,
    input  logic                               wr_en,
    input  logic [$clog2(SETS)-1:0]            wr_row,
    input  logic [ENTRIES-1:0]                 wr_be,
    input  logic [ENTRIES-1:0][LH_W-1:0]       wr_data
);

    logic [ENTRIES-1:0][LH_W-1:0] mem [SETS];
    logic [ENTRIES-1:0][LH_W-1:0] fwd;

    // Same-cycle write to the read row wins, entry by entry.
    always_comb begin
        fwd = mem[rd_row];
        for (int e = 0; e < int'(ENTRIES); e++) begin
            if (wr_en && wr_be[e] && (wr_row == rd_row)) begin
                fwd[e] = wr_data[e];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            for (int e = 0; e < int'(ENTRIES); e++) begin
                if (wr_be[e]) begin
                    mem[wr_row][e] <= wr_data[e];
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (nRST) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= fwd;
        end
    end

endmodule

// File: rtl/lht_mp.sv
// Local history table with N_UPDATE queued update ports, one drain per cycle and a
// post-reset clearing sweep. Queue entries use the package geometry types.
module lht_mp
    import lht_mp_pkg::*;
#(
    parameter int unsigned LHT_SETS              = LHT_SETS_DFLT,
    parameter int unsigned LHT_ENTRIES_PER_BLOCK = LHT_ENTRIES_PER_BLOCK_DFLT,
    parameter int unsigned LH_LENGTH             = LH_LENGTH_DFLT,
    parameter int unsigned ASID_WIDTH            = ASID_WIDTH_DFLT,
    parameter int unsigned N_UPDATE              = N_UPDATE_DFLT,
    parameter int unsigned UQ_DEPTH              = UQ_DEPTH_DFLT
) (
    input  logic                                              CLK,
    input  logic                                              nRST,
    input  logic                                              valid_REQ,
    input  logic [31:0]                                       full_PC_REQ,
    input  logic [ASID_WIDTH-1:0]                             ASID_REQ,
    output logic [LHT_ENTRIES_PER_BLOCK-1:0][LH_LENGTH-1:0]   LH_by_instr_RESP,
    input  logic [N_UPDATE-1:0]                               update_valid,
    output logic [N_UPDATE-1:0]                               update_ready,
    input  logic [N_UPDATE-1:0][31:0]                         update_start_full_PC,
    input  logic [N_UPDATE-1:0][ASID_WIDTH-1:0]               update_ASID,
    input  logic [N_UPDATE-1:0][LH_LENGTH-1:0]                update_LH,
    output logic                                              init_done,
    output logic [$clog2(UQ_DEPTH+1)-1:0]                     uq_count
);

    localparam int unsigned ROW_W = $clog2(LHT_SETS);
    localparam int unsigned PTR_W = $clog2(UQ_DEPTH);
    localparam int unsigned CNT_W = $clog2(UQ_DEPTH + 1);

    lht_state_t       state_q, state_d;
    logic [ROW_W-1:0] init_row_q;

    uq_entry_t        uq_mem [UQ_DEPTH];
    logic [PTR_W-1:0] head_q, tail_q;
    uq_entry_t        head_e;
    uq_entry_t        upd_e  [N_UPDATE];
    logic [PTR_W-1:0] slot   [N_UPDATE];
    logic [N_UPDATE-1:0] acc;
    logic [N_UPDATE-1:0] ready_d;
    int unsigned      n_acc;
    logic             drain;
    logic [CNT_W-1:0] cnt_d;

    logic                                            ram_re;
    logic [ROW_W-1:0]                                ram_rrow;
    logic                                            ram_we;
    logic [ROW_W-1:0]                                ram_wrow;
    logic [LHT_ENTRIES_PER_BLOCK-1:0]                ram_be;
    logic [LHT_ENTRIES_PER_BLOCK-1:0][LH_LENGTH-1:0] ram_wdata;

    // Queue pointers wrap modulo UQ_DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p, input int unsigned n);
        int unsigned s;
        s = int'(p) + n;
        if (s >= UQ_DEPTH) s = s - UQ_DEPTH;
        return PTR_W'(s);
    endfunction

    always_ff @(posedge CLK) begin
        if (nRST) state_q <= LHT_INIT;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            LHT_INIT: if (init_row_q == ROW_W'(LHT_SETS - 1)) state_d = LHT_RUN;
            LHT_RUN:  state_d = LHT_RUN;
            default:  state_d = LHT_INIT;
        endcase
    end

    // Table port control: clearing sweep in INIT, queue-head drain and reads in RUN.
    always_comb begin
        ram_we    = 1'b0;
        ram_wrow  = '0;
        ram_be    = '0;
        ram_wdata = '0;
        ram_re    = 1'b0;
        drain     = 1'b0;
        case (state_q)
            LHT_INIT: begin
                ram_we   = 1'b1;
                ram_wrow = init_row_q;
                ram_be   = '1;
            end
            LHT_RUN: begin
                drain     = (uq_count != '0);
                ram_we    = drain;
                ram_wrow  = head_e.row;
                ram_be    = LHT_ENTRIES_PER_BLOCK'(1) << head_e.entry;
                ram_wdata = {LHT_ENTRIES_PER_BLOCK{head_e.lh}};
                ram_re    = valid_REQ;
            end
            default: ;
        endcase
    end

    assign head_e   = uq_mem[head_q];
    assign ram_rrow = lht_row(full_PC_REQ, ASID_REQ);

    // Accepted ports are packed into consecutive slots in ascending port order.
    always_comb begin
        acc   = update_valid & update_ready;
        n_acc = 0;
        for (int k = 0; k < int'(N_UPDATE); k++) begin
            upd_e[k].row   = lht_row(update_start_full_PC[k], update_ASID[k]);
            upd_e[k].entry = lht_entry(update_start_full_PC[k]);
            upd_e[k].lh    = update_LH[k];
            slot[k]        = ptr_add(tail_q, n_acc);
            if (acc[k]) n_acc = n_acc + 1;
        end
        cnt_d = CNT_W'(int'(uq_count) + int'(n_acc) - (drain ? 1 : 0));
        for (int k = 0; k < int'(N_UPDATE); k++) begin
            ready_d[k] = (state_d == LHT_RUN) && ((int'(UQ_DEPTH) - int'(cnt_d)) > k);
        end
    end

    always_ff @(posedge CLK) begin
        for (int k = 0; k < int'(N_UPDATE); k++) begin
            if (acc[k]) uq_mem[slot[k]] <= upd_e[k];
        end
    end

    always_ff @(posedge CLK) begin
        if (nRST) begin
            init_row_q   <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            uq_count     <= '0;
            update_ready <= '0;
            init_done    <= 1'b0;
        end else begin
            if (state_q == LHT_INIT) init_row_q <= init_row_q + ROW_W'(1);
            if (drain) head_q <= ptr_add(head_q, 1);
            tail_q       <= ptr_add(tail_q, n_acc);
            uq_count     <= cnt_d;
            update_ready <= ready_d;
            init_done    <= (state_d == LHT_RUN);
        end
    end

    lht_mp_ram #(
        .SETS    (LHT_SETS),
        .ENTRIES (LHT_ENTRIES_PER_BLOCK),
        .LH_W    (LH_LENGTH)
    ) u_ram (
        .CLK     (CLK),
        .nRST    (nRST),
        .rd_en   (ram_re),
        .rd_row  (ram_rrow),
        .rd_data (LH_by_instr_RESP),
        .wr_en   (ram_we),
        .wr_row  (ram_wrow),
        .wr_be   (ram_be),
        .wr_data (ram_wdata)
    );

endmodule

// File: tb/tb_lht_mp.sv
// Self-checking bench for lht_mp: directed vector table, hand sequences for init/reset,
// and random traffic checked every cycle against a queue-and-array reference model.
module tb_lht_mp;

    localparam int unsigned SETS = 32;
    localparam int unsigned ENTS = 8;
    localparam int unsigned UQD  = 4;

    logic             CLK;
    logic             nRST;
    logic             valid_REQ;
    logic [31:0]      full_PC_REQ;
    logic [8:0]       ASID_REQ;
    logic [7:0][7:0]  LH_by_instr_RESP;
    logic [1:0]       update_valid;
    logic [1:0]       update_ready;
    logic [1:0][31:0] update_start_full_PC;
    logic [1:0][8:0]  update_ASID;
    logic [1:0][7:0]  update_LH;
    logic             init_done;
    logic [2:0]       uq_count;

    lht_mp dut (
        .CLK                  (CLK),
        .nRST                 (nRST),
        .valid_REQ            (valid_REQ),
        .full_PC_REQ          (full_PC_REQ),
        .ASID_REQ             (ASID_REQ),
        .LH_by_instr_RESP     (LH_by_instr_RESP),
        .update_valid         (update_valid),
        .update_ready         (update_ready),
        .update_start_full_PC (update_start_full_PC),
        .update_ASID          (update_ASID),
        .update_LH            (update_LH),
        .init_done            (init_done),
        .uq_count             (uq_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: plain table array plus a FIFO of pending writes.
    typedef struct { int row; int ent; logic [7:0] lh; } mq_t;
    mq_t         m_q[$];
    logic [7:0]  m_tab [SETS][ENTS];
    logic [63:0] m_resp;
    bit          m_done  = 0;
    bit          m_known = 0;
    int          m_left  = 0;

    function automatic int ref_row(logic [31:0] pc, logic [8:0] asid);
        return int'(((pc >> 4) ^ 32'(asid)) % SETS);
    endfunction

    function automatic int ref_ent(logic [31:0] pc);
        return int'((pc >> 1) % ENTS);
    endfunction

    function automatic logic [1:0] exp_ready();
        logic [1:0] r;
        for (int k = 0; k < 2; k++) r[k] = m_done && ((int'(UQD) - m_q.size()) > k);
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_state();
        if (m_known) begin
            check("init_done", 64'(init_done), 64'(m_done));
            check("uq_count", 64'(uq_count), 64'(m_q.size()));
            check("update_ready", 64'(update_ready), 64'(exp_ready()));
            check("resp", LH_by_instr_RESP, m_resp);
        end
    endtask

    // Advance the model by one cycle using the current inputs, clock the DUT, then compare.
    task automatic tick();
        logic [1:0] acc;
        mq_t        e;
        int         r;
        if (nRST) begin
            m_q.delete();
            m_resp = '0;
            m_done = 0;
            m_left = SETS;
            foreach (m_tab[i, j]) m_tab[i][j] = 8'h00;
            m_known = 1;
        end else if (m_known) begin
            if (!m_done) begin
                m_left--;
                if (m_left == 0) m_done = 1;
            end else begin
                acc = update_valid & exp_ready();
                if (m_q.size() > 0) begin
                    e = m_q.pop_front();
                    m_tab[e.row][e.ent] = e.lh;
                end
                if (valid_REQ) begin
                    r = ref_row(full_PC_REQ, ASID_REQ);
                    for (int s = 0; s < int'(ENTS); s++) m_resp[s*8 +: 8] = m_tab[r][s];
                end
                for (int k = 0; k < 2; k++) begin
                    if (acc[k]) m_q.push_back('{row: ref_row(update_start_full_PC[k], update_ASID[k]),
                                                ent: ref_ent(update_start_full_PC[k]),
                                                lh:  update_LH[k]});
                end
            end
        end
        @(posedge CLK);
        #1;
        check_state();
    endtask

    task automatic set_idle();
        valid_REQ    = 1'b0;
        update_valid = 2'b00;
    endtask

    task automatic wait_init(output int cyc);
        cyc = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (init_done) begin
                cyc = i;
                break;
            end
        end
    endtask

    typedef struct {
        logic        req;
        logic [31:0] pc;
        logic [8:0]  asid;
        logic [1:0]  uv;
        logic [31:0] upc0;
        logic [7:0]  ulh0;
        logic [31:0] upc1;
        logic [7:0]  ulh1;
        logic [8:0]  uasid;
        int          exp_cnt;
        logic [1:0]  exp_rdy;
        int          chk_slot;
        logic [7:0]  exp_lh;
    } vec_t;

    function automatic vec_t mk(logic req, logic [31:0] pc, logic [8:0] asid, logic [1:0] uv,
                                logic [31:0] upc0, logic [7:0] ulh0, logic [31:0] upc1,
                                logic [7:0] ulh1, logic [8:0] uasid, int cnt, logic [1:0] rdy,
                                int slot, logic [7:0] lh);
        vec_t v;
        v.req = req; v.pc = pc; v.asid = asid; v.uv = uv;
        v.upc0 = upc0; v.ulh0 = ulh0; v.upc1 = upc1; v.ulh1 = ulh1; v.uasid = uasid;
        v.exp_cnt = cnt; v.exp_rdy = rdy; v.chk_slot = slot; v.exp_lh = lh;
        return v;
    endfunction

    vec_t vecs [17];
    int   cyc;

    initial begin
        //               req pc        asid  uv     upc0   ulh0   upc1   ulh1   uasid  cnt rdy    slot lh
        vecs[0]  = mk(0, 32'h0,   9'h0, 2'b01, 32'h12, 8'hA5, 32'h0,  8'h00, 9'h00, 1, 2'b11, -1, 8'h00);
        vecs[1]  = mk(1, 32'h10,  9'h0, 2'b00, 32'h0,  8'h00, 32'h0,  8'h00, 9'h00, 0, 2'b11,  1, 8'hA5);
        vecs[2]  = mk(0, 32'h0,   9'h0, 2'b11, 32'h20, 8'h11, 32'h20, 8'h22, 9'h00, 2, 2'b11, -1, 8'h00);
        vecs[3]  = mk(0, 32'h0,   9'h0, 2'b00, 32'h0,  8'h00, 32'h0,  8'h00, 9'h00, 1, 2'b11, -1, 8'h00);
        vecs[4]  = mk(0, 32'h0,   9'h0, 2'b00, 32'h0,  8'h00, 32'h0,  8'h00, 9'h00, 0, 2'b11, -1, 8'h00);
        vecs[5]  = mk(1, 32'h20,  9'h0, 2'b00, 32'h0,  8'h00, 32'h0,  8'h00, 9'h00, 0, 2'b11,  0, 8'h22);
        vecs[6]  = mk(0, 32'h0,   9'h0, 2'b01, 32'h30, 8'h5C, 32'h0,  8'h00, 9'h1F, 1, 2'b11, -1, 8'h00);
        vecs[7]  = mk(1, 32'h30,  9'h0, 2'b00, 32'h0,  8'h00, 32'h0,  8'h00, 9'h00, 0, 2'b11,  0, 8'h00);
        vecs[8]  = mk(1, 32'h1E0, 9'h2, 2'b00, 32'h0,  8'h00, 32'h0,  8'h00, 9'h00, 0, 2'b11,  0, 8'h5C);
        vecs[9]  = mk(0, 32'h0,   9'h0, 2'b11, 32'h40, 8'h01, 32'h42, 8'h02, 9'h00, 2, 2'b11, -1, 8'h00);
        vecs[10] = mk(0, 32'h0,   9'h0, 2'b11, 32'h44, 8'h03, 32'h46, 8'h04, 9'h00, 3, 2'b01, -1, 8'h00);
        vecs[11] = mk(0, 32'h0,   9'h0, 2'b11, 32'h48, 8'h05, 32'h4A, 8'h06, 9'h00, 3, 2'b01, -1, 8'h00);
        vecs[12] = mk(0, 32'h0,   9'h0, 2'b00, 32'h0,  8'h00, 32'h0,  8'h00, 9'h00, 2, 2'b11, -1, 8'h00);
        vecs[13] = mk(0, 32'h0,   9'h0, 2'b00, 32'h0,  8'h00, 32'h0,  8'h00, 9'h00, 1, 2'b11, -1, 8'h00);
        vecs[14] = mk(0, 32'h0,   9'h0, 2'b00, 32'h0,  8'h00, 32'h0,  8'h00, 9'h00, 0, 2'b11, -1, 8'h00);
        vecs[15] = mk(1, 32'h40,  9'h0, 2'b00, 32'h0,  8'h00, 32'h0,  8'h00, 9'h00, 0, 2'b11,  4, 8'h05);
        vecs[16] = mk(1, 32'h40,  9'h0, 2'b00, 32'h0,  8'h00, 32'h0,  8'h00, 9'h00, 0, 2'b11,  5, 8'h00);

        nRST                 = 1'b1;
        full_PC_REQ          = '0;
        ASID_REQ             = '0;
        update_start_full_PC = '0;
        update_ASID          = '0;
        update_LH            = '0;
        set_idle();
        update_valid = 2'b11;
        tick();

        // Reset release, then a held request throughout the clearing sweep.
        nRST         = 1'b0;
        update_valid = 2'b11;
        valid_REQ    = 1'b1;
        full_PC_REQ  = 32'h10;
        wait_init(cyc);
        check("init_latency", 64'(cyc), 64'd32);
        set_idle();

        foreach (vecs[i]) begin
            valid_REQ               = vecs[i].req;
            full_PC_REQ             = vecs[i].pc;
            ASID_REQ                = vecs[i].asid;
            update_valid            = vecs[i].uv;
            update_start_full_PC[0] = vecs[i].upc0;
            update_start_full_PC[1] = vecs[i].upc1;
            update_LH[0]            = vecs[i].ulh0;
            update_LH[1]            = vecs[i].ulh1;
            update_ASID[0]          = vecs[i].uasid;
            update_ASID[1]          = vecs[i].uasid;
            tick();
            check($sformatf("vec%0d_count", i), 64'(uq_count), 64'(vecs[i].exp_cnt));
            check($sformatf("vec%0d_ready", i), 64'(update_ready), 64'(vecs[i].exp_rdy));
            if (vecs[i].chk_slot >= 0)
                check($sformatf("vec%0d_slot%0d", i, vecs[i].chk_slot),
                      64'(LH_by_instr_RESP[vecs[i].chk_slot]), 64'(vecs[i].exp_lh));
        end
        set_idle();

        // Random traffic over a few rows so updates and reads collide often.
        for (int c = 0; c < 600; c++) begin
            nRST        = ($urandom_range(0, 249) == 0);
            valid_REQ   = 1'($urandom_range(0, 1));
            full_PC_REQ = $urandom & 32'hFFFF_F03F;
            ASID_REQ    = 9'($urandom_range(0, 3)) | 9'($urandom_range(0, 1) << 7);
            for (int k = 0; k < 2; k++) begin
                update_valid[k]         = ($urandom_range(0, 2) != 0);
                update_start_full_PC[k] = $urandom & 32'hFFFF_F03F;
                update_ASID[k]          = 9'($urandom_range(0, 3)) | 9'($urandom_range(0, 1) << 6);
                update_LH[k]            = 8'($urandom);
            end
            tick();
        end

        // Reset with three updates in flight, then confirm the sweep cleared everything.
        nRST = 1'b1;
        set_idle();
        tick();
        nRST = 1'b0;
        wait_init(cyc);
        check("reinit_latency", 64'(cyc), 64'd32);
        update_ASID             = '0;
        update_valid            = 2'b11;
        update_start_full_PC[0] = 32'h40; update_LH[0] = 8'hAA;
        update_start_full_PC[1] = 32'h52; update_LH[1] = 8'hBB;
        tick();
        update_start_full_PC[0] = 32'h44; update_LH[0] = 8'hCC;
        update_start_full_PC[1] = 32'h56; update_LH[1] = 8'hDD;
        tick();
        check("fill_count", 64'(uq_count), 64'd3);
        nRST = 1'b1;
        tick();
        check("midrst_count", 64'(uq_count), 64'd0);
        check("midrst_ready", 64'(update_ready), 64'd0);
        check("midrst_done", 64'(init_done), 64'd0);
        nRST = 1'b0;
        set_idle();
        wait_init(cyc);
        check("midrst_init_latency", 64'(cyc), 64'd32);
        valid_REQ   = 1'b1;
        ASID_REQ    = '0;
        full_PC_REQ = 32'h40;
        tick();
        check("post_rst_row4", LH_by_instr_RESP, 64'd0);
        full_PC_REQ = 32'h50;
        tick();
        check("post_rst_row5", LH_by_instr_RESP, 64'd0);
        set_idle();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
